// File: rtl/alu_arb2.sv
// Two-port round-robin front end sharing one 32-bit ALU; result lands in rsp_* one cycle after accept.
// Accepts only while the response slot is free (empty or being drained); a stalled response blocks both ports.
module alu_arb2 #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_f,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_f,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic             rsp_zero,
  output logic             rsp_of,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  logic             rr;
  logic             free;
  logic             win0;
  logic             win1;
  logic             acc;
  logic             sel;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [2:0]       op_f;
  logic [TAG_W-1:0] op_tag;
  logic [31:0]      sum;
  logic [31:0]      diff;
  logic [31:0]      alu_y;
  logic             alu_of;

  // The slot is free if empty or if its current contents leave this cycle.
  assign free       = (state == IDLE) || rsp_ready;
  assign win1       = req1_valid && (!req0_valid || rr);
  assign win0       = req0_valid && !win1;
  assign req0_ready = !reset && free && win0;
  assign req1_ready = !reset && free && win1;
  assign acc        = req0_ready || req1_ready;
  assign sel        = req1_ready;
  assign rsp_valid  = (state == HOLD);

  always_comb begin
    op_a   = req0_a;
    op_b   = req0_b;
    op_f   = req0_f;
    op_tag = req0_tag;
    if (sel) begin
      op_a   = req1_a;
      op_b   = req1_b;
      op_f   = req1_f;
      op_tag = req1_tag;
    end
  end

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    alu_y  = 32'd0;
    alu_of = 1'b0;
    case (op_f)
      3'b000: alu_y = op_a & op_b;
      3'b001: alu_y = op_a | op_b;
      3'b010: begin
        alu_y  = sum;
        alu_of = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      3'b110: begin
        alu_y  = diff;
        alu_of = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
      end
      3'b111: alu_y = {31'd0, ($signed(op_a) < $signed(op_b))};
      default: begin
        alu_y  = 32'd0;
        alu_of = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr       <= 1'b0;
      rsp_y    <= 32'd0;
      rsp_zero <= 1'b0;
      rsp_of   <= 1'b0;
      rsp_src  <= 1'b0;
      rsp_tag  <= '0;
    end else if (acc) begin
      state    <= HOLD;
      rr       <= ~sel;
      rsp_y    <= alu_y;
      rsp_zero <= (alu_y == 32'd0);
      rsp_of   <= alu_of;
      rsp_src  <= sel;
      rsp_tag  <= op_tag;
    end else if (rsp_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_arb2.sv
// Randomised and directed bench for alu_arb2 against a transaction-level model of arbiter and ALU.
module tb_alu_arb2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_f, req1_f;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_zero, rsp_of, rsp_src;
  logic [3:0]  rsp_tag;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: one optional pending response plus the round-robin pointer.
  logic        m_valid;
  logic [31:0] m_y;
  logic        m_zero, m_of, m_src;
  logic [3:0]  m_tag;
  int          m_rr;
  logic        g0, g1;

  alu_arb2 #(.TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_f(req0_f), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_f(req1_f), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_zero(rsp_zero),
    .rsp_of(rsp_of), .rsp_src(rsp_src), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] y, output logic of);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    y  = 32'd0;
    of = 1'b0;
    case (f)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b010: begin
        r  = sa + sb;
        y  = r[31:0];
        of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b110: begin
        r  = sa - sb;
        y  = r[31:0];
        of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b111: y = (sa < sb) ? 32'd1 : 32'd0;
      default: ;
    endcase
  endfunction

  // Inputs are set after a falling edge; this checks readies, advances one clock and checks outputs.
  task automatic cycle();
    int          win;
    logic        can_take;
    logic [31:0] y;
    logic        of;
    #1;
    can_take = !reset && (!m_valid || rsp_ready);
    win = -1;
    if (can_take) begin
      if (req0_valid && req1_valid) win = m_rr;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    g0 = req0_ready;
    g1 = req1_ready;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, win == 0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, win == 1});
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_y = 0; m_zero = 0; m_of = 0; m_src = 0; m_tag = 0; m_rr = 0;
    end else if (win >= 0) begin
      if (win == 0) begin
        ref_alu(req0_f, req0_a, req0_b, y, of);
        m_tag = req0_tag;
      end else begin
        ref_alu(req1_f, req1_a, req1_b, y, of);
        m_tag = req1_tag;
      end
      m_valid = 1'b1; m_y = y; m_of = of; m_zero = (y == 0); m_src = win[0];
      m_rr = 1 - win;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("rsp_y", rsp_y, m_y);
      chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
      chk("rsp_of", {31'd0, rsp_of}, {31'd0, m_of});
      chk("rsp_src", {31'd0, rsp_src}, {31'd0, m_src});
      chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, m_tag});
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
  endtask

  task automatic set_req(input int p, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
    if (p == 0) begin
      req0_valid = 1'b1; req0_f = f; req0_a = a; req0_b = b; req0_tag = tag;
    end else begin
      req1_valid = 1'b1; req1_f = f; req1_a = a; req1_b = b; req1_tag = tag;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic rand_req(input int p);
    logic [2:0] f;
    f = 3'($urandom_range(0, 7));
    set_req(p, f, ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom,
            ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom, 4'($urandom));
  endtask

  logic [31:0] held_y;
  logic [3:0]  held_tag;

  initial begin
    idle_inputs();
    req0_a = 0; req0_b = 0; req0_f = 0; req0_tag = 0;
    req1_a = 0; req1_b = 0; req1_f = 0; req1_tag = 0;
    m_valid = 0; m_y = 0; m_zero = 0; m_of = 0; m_src = 0; m_tag = 0; m_rr = 0;
    @(negedge clk);
    do_reset();
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_y", rsp_y, 32'd0);
    chk("rst_flags", {28'd0, rsp_zero, rsp_of, rsp_src, 1'b0}, 32'd0);
    chk("rst_tag", {28'd0, rsp_tag}, 32'd0);

    // Signed add overflow from port 0.
    set_req(0, 3'b010, 32'h7FFFFFFF, 32'h1, 4'd3);
    cycle();
    chk("add_y", rsp_y, 32'h80000000);
    chk("add_of", {31'd0, rsp_of}, 32'd1);
    chk("add_zero", {31'd0, rsp_zero}, 32'd0);
    chk("add_src", {31'd0, rsp_src}, 32'd0);
    chk("add_tag", {28'd0, rsp_tag}, 32'd3);
    idle_inputs();
    cycle();

    // Both ports streaming: grants alternate starting from port 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rand_req(0);
      rand_req(1);
      cycle();
      chk("alt_grant1", {31'd0, g1}, i % 2);
      chk("alt_src", {31'd0, rsp_src}, i % 2);
    end
    idle_inputs();
    cycle();

    // Stalled response blocks a waiting requester, then it goes through on release.
    set_req(0, 3'b001, 32'h0F0F0000, 32'h000000F0, 4'd9);
    cycle();
    held_y = rsp_y;
    held_tag = rsp_tag;
    req0_valid = 1'b0;
    rsp_ready = 1'b0;
    set_req(1, 3'b000, 32'hFFFF0000, 32'h12345678, 4'd5);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_rdy1", {31'd0, g1}, 32'd0);
      chk("stall_y", rsp_y, held_y);
      chk("stall_tag", {28'd0, rsp_tag}, {28'd0, held_tag});
    end
    rsp_ready = 1'b1;
    cycle();
    chk("release_rdy1", {31'd0, g1}, 32'd1);
    chk("release_y", rsp_y, 32'h12340000);
    chk("release_src", {31'd0, rsp_src}, 32'd1);
    idle_inputs();

    set_req(1, 3'b111, 32'hFFFFFFFF, 32'h1, 4'd1);
    cycle();
    chk("slt_y", rsp_y, 32'd1);
    chk("slt_of", {31'd0, rsp_of}, 32'd0);
    idle_inputs();
    set_req(1, 3'b110, 32'd5, 32'd5, 4'd2);
    cycle();
    chk("sub0_y", rsp_y, 32'd0);
    chk("sub0_zero", {31'd0, rsp_zero}, 32'd1);
    idle_inputs();
    set_req(1, 3'b110, 32'h80000000, 32'h1, 4'd4);
    cycle();
    chk("subof_y", rsp_y, 32'h7FFFFFFF);
    chk("subof_of", {31'd0, rsp_of}, 32'd1);
    idle_inputs();
    set_req(1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6);
    cycle();
    chk("f011_y", rsp_y, 32'd0);
    chk("f011_zero", {31'd0, rsp_zero}, 32'd1);
    chk("f011_of", {31'd0, rsp_of}, 32'd0);

    // Reset while holding a stalled response with both requesters waiting.
    idle_inputs();
    set_req(1, 3'b010, 32'd10, 32'd20, 4'd7);
    cycle();
    rsp_ready = 1'b0;
    rand_req(0);
    rand_req(1);
    cycle();
    reset = 1'b1;
    cycle();
    chk("rst_hold_rdy", {30'd0, g0, g1}, 32'd0);
    chk("rst_hold_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    chk("post_rst_g0", {31'd0, g0}, 32'd1);
    chk("post_rst_g1", {31'd0, g1}, 32'd0);

    // Random traffic with random backpressure and occasional reset.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 60) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if ($urandom_range(0, 2) != 0) rand_req(0);
      if ($urandom_range(0, 2) != 0) rand_req(1);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arb2.md
ALU_ARB2 -- requirements
Module: alu_arb2

Interface
REQ-001 The block SHALL have parameter TAG_W, default 4, the width of the request/response tag.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have ports reqN_valid (N=0,1), input, 1, requester N presents an operation.
REQ-005 The block SHALL have ports reqN_ready (N=0,1), output, 1, the operation from requester N is accepted this cycle.
REQ-006 The block SHALL have ports reqN_a, reqN_b (N=0,1), input, 32, the operands.
REQ-007 The block SHALL have ports reqN_f (N=0,1), input, 3, the operation code.
REQ-008 The block SHALL have ports reqN_tag (N=0,1), input, TAG_W, an opaque tag returned with the result.
REQ-009 The block SHALL have port rsp_valid, output, 1, the response registers hold a result.
REQ-010 The block SHALL have port rsp_ready, input, 1, the consumer takes the response.
REQ-011 The block SHALL have port rsp_y, output, 32, the result.
REQ-012 The block SHALL have port rsp_zero, output, 1, high when rsp_y == 0.
REQ-013 The block SHALL have port rsp_of, output, 1, the signed overflow flag.
REQ-014 The block SHALL have port rsp_src, output, 1, the index of the requester that issued the result.
REQ-015 The block SHALL have port rsp_tag, output, TAG_W, a copy of the accepted reqN_tag.

Function
REQ-016 The block SHALL contain one shared 32-bit ALU computing F=000 AND, 001 OR, 010 ADD, 110 SUB and 111 signed SLT (Y=1 if A<B else 0); every other F code SHALL give Y=0, OF=0.
REQ-017 OF SHALL be set for ADD when the operand signs are equal and the sum sign differs, set for SUB when the operand signs differ and the result sign differs from A, and SHALL be 0 for all other ops; arithmetic is modulo 2^32.
REQ-018 The block SHALL implement two states: IDLE (rsp_valid=0) and HOLD (rsp_valid=1).
REQ-019 The block SHALL be able to accept a request when the output is free, defined as free = (state==IDLE) || rsp_ready.
REQ-020 The grant SHALL follow round-robin: when both reqN_valid are high, the port named by pointer rr wins; when only one is valid, that one wins regardless of rr.
REQ-021 reqN_ready SHALL be high only for the winning port, and only when free.
REQ-022 reqN_ready SHALL be combinational from valids, rr, state and rsp_ready.
REQ-023 At most one reqN_ready SHALL be high per cycle.
REQ-024 On acceptance, the block SHALL register the ALU result, zero flag, OF, source index and tag into the rsp_* registers at the next edge, and the state SHALL become HOLD.
REQ-025 Latency SHALL be 1 cycle from acceptance to rsp_valid.
REQ-026 Throughput SHALL be 1 result per cycle when rsp_ready=1.
REQ-027 On acceptance from port k, rr SHALL become the other port; rr SHALL be unchanged when nothing is accepted.
REQ-028 In HOLD with rsp_ready=1 and no acceptance, the state SHALL return to IDLE.
REQ-029 In HOLD with rsp_ready=1 and an acceptance in the same cycle, the state SHALL remain HOLD with the new result.
REQ-030 In HOLD with rsp_ready=0, all rsp_* outputs SHALL be held stable and both reqN_ready SHALL be 0.
REQ-031 A requester SHALL be allowed to change or drop its inputs when its ready is low; the block SHALL sample its inputs only in the accept cycle.

Reset
REQ-032 When reset=1 at an edge, the block SHALL set the state to IDLE, rsp_valid=0, rsp_y=0, rsp_zero=0, rsp_of=0, rsp_src=0, rsp_tag=0 and rr=0.
REQ-033 Any held response SHALL be discarded at reset.
REQ-034 While reset=1, both reqN_ready SHALL be 0, and no request SHALL be accepted in that cycle.
REQ-035 Reset asserted in HOLD with rsp_ready=0 SHALL still clear rsp_valid on the next edge.

Verification
REQ-036 The bench SHALL cover: reset, then req0 ADD a=0x7FFFFFFF b=1 tag=3 with rsp_ready=1 -> next cycle rsp_valid=1, y=0x80000000, of=1, zero=0, src=0, tag=3.
REQ-037 The bench SHALL cover: both ports valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting at 0, with one response per cycle and rsp_src matching.
REQ-038 The bench SHALL cover: a response pending with rsp_ready=0 for 3 cycles while req1 is valid -> rsp_* stable and req1_ready=0; when rsp_ready rises, req1 is accepted that cycle and its result appears next cycle.
REQ-039 The bench SHALL cover: req1 SLT a=0xFFFFFFFF b=1 -> y=1, of=0.
REQ-040 The bench SHALL cover: SUB a=5 b=5 -> y=0, zero=1.
REQ-041 The bench SHALL cover: SUB a=0x80000000 b=1 -> y=0x7FFFFFFF, of=1.
REQ-042 The bench SHALL cover: F=011 with a=0xFFFFFFFF, b=0xFFFFFFFF -> y=0, zero=1, of=0.
REQ-043 The bench SHALL cover: reset pulsed in HOLD with rsp_ready=0, both requesters valid -> next cycle rsp_valid=0, no ready seen during reset, and the first grant after reset goes to port 0.
